alu_issue_decoder: RTL and testbench
====================================

// Module: alu_issue_decoder
// PURPOSE
//  Decode/issue stage that drives the RV32I integer ALU: accepts an instruction word plus rs1/rs2 data
//  over valid/ready, decodes R-type (0110011) and I-type ALU (0010011) encodings into the ALU's 5-bit
//  op code, 12-bit immediate and operand pair, and presents them to execute through a 2-entry skid buffer.
//  Sits between register-file read and the combinational ALU; absorbs one cycle of execute backpressure.
// PARAMETERS
//  XLEN   32  operand width; only 32 supported
//  CNT_W  32  width of perf counters (optional feature only)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous active-high reset
//  in_valid     in   1     upstream has instruction + operands
//  in_ready     out  1     stage can accept (registered)
//  in_instr     in   32    instruction word
//  in_rs1_data  in   XLEN  rs1 value
//  in_rs2_data  in   XLEN  rs2 value
//  out_valid    out  1     decoded entry at head
//  out_ready    in   1     execute consumes head this cycle
//  out_op_code  out  5     ALU op code (table below)
//  out_operandA out  XLEN  = rs1 data
//  out_operandB out  XLEN  = rs2 data for R-type; 0 for I-type and illegal
//  out_immediate out 12    instr[31:20] for I-type; 0 otherwise
//  out_rd       out  5     instr[11:7]
//  out_illegal  out  1     instruction not an ALU R/I op
//  perf_issued  out  CNT_W entries popped (optional)
//  perf_illegal out  CNT_W illegal entries popped (optional)
// BEHAVIOUR
//  Op codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 ADDI10 SLLI11 SLTI12 SLTUI13 XORI14
//   SRLI15 SRAI16 ORI17 ANDI18; illegal -> 5'h1F (ALU default, result 0).
//  R-type: funct3 000/f7 0000000=ADD, 000/0100000=SUB, 001=SLL, 010=SLT, 011=SLTU, 100=XOR,
//   101/0000000=SRL, 101/0100000=SRA, 110=OR, 111=AND; f7 must be 0000000 except SUB/SRA, else illegal.
//  I-type: 000 ADDI, 010 SLTI, 011 SLTUI, 100 XORI, 110 ORI, 111 ANDI; 001 SLLI needs instr[31:25]=0;
//   101 SRLI needs instr[31:25]=0, SRAI needs 0100000; other funct7 -> illegal. Imm passed unmodified.
//  Any other major opcode -> illegal; illegal entries still flow through (not dropped).
//  Decode is combinational on input; decoded entry written into buffer on accept (in_valid & in_ready).
//  Buffer FSM: EMPTY(0) / ONE(1) / FULL(2). push=accept, pop=out_valid&out_ready.
//   EMPTY: push->ONE. ONE: push&!pop->FULL, pop&!push->EMPTY, both->ONE. FULL: pop->ONE (no push).
//  in_ready registered: 1 in EMPTY/ONE, 0 in FULL; next-state computed so no entry is ever lost.
//  out_valid = state!=EMPTY; head is oldest entry; order preserved; 1-cycle latency accept->out_valid.
//  Sustained throughput 1/cycle with out_ready held high; head fields stable while out_valid&!out_ready.
//  Reset (async, any time incl. mid-transfer): state EMPTY, in_ready 1 after release, out_valid 0,
//   all data outputs 0, out_op_code 0, out_illegal 0, counters 0; buffered entries discarded.
// CONFIGURATION
//  ALU_DEC_PERF_EN defined: perf_issued +1 per pop, perf_illegal +1 per pop with out_illegal; both
//   wrap modulo 2^CNT_W, reset to 0. Undefined: ports present, tied to 0, no counter flops.
// TESTING
//  1 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle op=0, A=5, B=7, rd=3, illegal=0.
//  2 ADDI x1,x0,-1 (0xFFF00093) -> op=10, imm=0xFFF, B=0; SRAI imm 0x403 (0x4030D093) -> op=16.
//  3 out_ready=0, push 3 back-to-back -> 2 accepted, in_ready=0 at FULL, 3rd held; release -> order 1,2,3.
//  4 LW opcode 0000011 and R-type f7=0000001 -> op=0x1F, illegal=1; with PERF_EN perf_illegal=2.
//  5 rst asserted while FULL -> out_valid=0 immediately, in_ready=1 after release, no stale entry popped.
//  6 1000 random R/I instrs, random out_ready -> scoreboard matches reference decode, no loss/dup.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
//
// Decode/issue stage feeding the RV32I integer ALU. An instruction word and
// its rs1/rs2 values arrive over valid/ready. R-type (0110011) and I-type ALU
// (0010011) encodings are decoded into the ALU's 5-bit op code, 12-bit
// immediate and operand pair. Decoded entries are held in a 2-entry skid
// buffer so one cycle of execute backpressure is absorbed without losing
// anything. Anything that is not a legal ALU R/I op is still passed through,
// marked illegal with op code 5'h1F.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid        upstream presents instruction + operands
//   in_ready        stage can accept (registered)
//   in_instr        32-bit instruction word
//   in_rs1_data     rs1 value
//   in_rs2_data     rs2 value
//   out_valid       decoded entry present at head
//   out_ready       execute consumes the head this cycle
//   out_op_code     ALU op code (0..18, 5'h1F for illegal)
//   out_operandA    rs1 value
//   out_operandB    rs2 value for R-type, 0 otherwise
//   out_immediate   instr[31:20] for I-type, 0 otherwise
//   out_rd          instr[11:7]
//   out_illegal     entry is not an ALU R/I op
//   perf_issued     entries popped (optional)
//   perf_illegal    illegal entries popped (optional)
//
// Build option
//   ALU_DEC_PERF_EN  when defined, perf_issued/perf_illegal are live
//                    wrapping counters; otherwise they are tied to 0 and no
//                    counter flops exist.
// ---------------------------------------------------------------------------
module alu_issue_decoder #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op_code,
  output logic [XLEN-1:0]  out_operandA,
  output logic [XLEN-1:0]  out_operandB,
  output logic [11:0]      out_immediate,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [4:0] OP_ILLEGAL = 5'h1F;

  // op(5) + A + B + imm(12) + rd(5) + illegal(1)
  localparam int ENTRY_W = 5 + XLEN + XLEN + 12 + 5 + 1;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               in_ready_q;
  logic [ENTRY_W-1:0] slot0;
  logic [ENTRY_W-1:0] slot1;
  logic [ENTRY_W-1:0] dec_entry;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r;
  logic       is_i;
  logic       dec_legal;
  logic [4:0] dec_op;
  logic       push;
  logic       pop;
  logic       unused_rs_fields;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign is_r   = (opcode == OPC_R);
  assign is_i   = (opcode == OPC_I);

  // The rs1 register index is resolved by the register file upstream; the
  // operand value arrives separately, so the field is not needed here.
  assign unused_rs_fields = ^in_instr[19:15];

  // Combinational decode of the incoming word. dec_legal is only raised for
  // encodings the ALU actually implements; every other combination falls
  // through as illegal, including wrong funct7 on shifts and R-type ops.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ILLEGAL;
    if (is_r) begin
      case (funct3)
        3'b000: begin
          if (funct7 == F7_ZERO) begin
            dec_op = 5'd0; dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_op = 5'd1; dec_legal = 1'b1;
          end
        end
        3'b001: if (funct7 == F7_ZERO) begin dec_op = 5'd2; dec_legal = 1'b1; end
        3'b010: if (funct7 == F7_ZERO) begin dec_op = 5'd3; dec_legal = 1'b1; end
        3'b011: if (funct7 == F7_ZERO) begin dec_op = 5'd4; dec_legal = 1'b1; end
        3'b100: if (funct7 == F7_ZERO) begin dec_op = 5'd5; dec_legal = 1'b1; end
        3'b101: begin
          if (funct7 == F7_ZERO) begin
            dec_op = 5'd6; dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_op = 5'd7; dec_legal = 1'b1;
          end
        end
        3'b110: if (funct7 == F7_ZERO) begin dec_op = 5'd8; dec_legal = 1'b1; end
        default: if (funct7 == F7_ZERO) begin dec_op = 5'd9; dec_legal = 1'b1; end
      endcase
    end else if (is_i) begin
      case (funct3)
        3'b000: begin dec_op = 5'd10; dec_legal = 1'b1; end
        3'b001: if (funct7 == F7_ZERO) begin dec_op = 5'd11; dec_legal = 1'b1; end
        3'b010: begin dec_op = 5'd12; dec_legal = 1'b1; end
        3'b011: begin dec_op = 5'd13; dec_legal = 1'b1; end
        3'b100: begin dec_op = 5'd14; dec_legal = 1'b1; end
        3'b101: begin
          if (funct7 == F7_ZERO) begin
            dec_op = 5'd15; dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_op = 5'd16; dec_legal = 1'b1;
          end
        end
        3'b110: begin dec_op = 5'd17; dec_legal = 1'b1; end
        default: begin dec_op = 5'd18; dec_legal = 1'b1; end
      endcase
    end
  end

  // Pack the decoded entry. Operand B and the immediate are zeroed whenever
  // they do not apply so the ALU sees clean inputs for illegal entries.
  assign dec_entry = {
    dec_legal ? dec_op : OP_ILLEGAL,
    in_rs1_data,
    (dec_legal && is_r) ? in_rs2_data : {XLEN{1'b0}},
    (dec_legal && is_i) ? in_instr[31:20] : 12'd0,
    in_instr[11:7],
    ~dec_legal
  };

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  // Next-state for the skid buffer. FULL never sees a push because in_ready
  // is low there, which is what guarantees nothing gets overwritten.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (push) state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_FULL;
        else if (pop && !push) state_nxt = ST_EMPTY;
      end
      ST_FULL: if (pop) state_nxt = ST_ONE;
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State register plus the registered in_ready, derived from the next
  // state so it already reflects this cycle's push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  // Entry storage. slot0 is always the head; slot1 only holds the second
  // entry while FULL and shifts forward when the head is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (push) slot0 <= dec_entry;
        ST_ONE: begin
          if (push && pop) slot0 <= dec_entry;
          else if (push)   slot1 <= dec_entry;
        end
        ST_FULL: if (pop) slot0 <= slot1;
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal} = slot0;

`ifdef ALU_DEC_PERF_EN
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  // Pop-based counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (pop) begin
      issued_cnt <= issued_cnt + 1'b1;
      if (out_illegal) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign perf_issued  = issued_cnt;
  assign perf_illegal = illegal_cnt;
`else
  assign perf_issued  = '0;
  assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_decoder
//
// Scoreboard bench for alu_issue_decoder. Directed cases cover reset state,
// ADD/ADDI/SRAI decode, backpressure into FULL, illegal encodings and reset
// while FULL; then randomized R/I (and garbage) instructions are checked
// against a table-driven reference decode. Expected entries are queued when
// an accept happens; an independent monitor pops and compares on each
// out_valid & out_ready. Honors ALU_DEC_PERF_EN for counter expectations.
// ---------------------------------------------------------------------------
module tb_alu_issue_decoder;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_op_code;
  logic [31:0] out_operandA;
  logic [31:0] out_operandB;
  logic [11:0] out_immediate;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] perf_issued;
  logic [31:0] perf_illegal;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   pop_cnt = 0;
  int   ill_cnt = 0;

  // Reference encoding table rows: {opcode(7), funct3(3), funct7_any(1), funct7(7), op(5)}
  logic [22:0] tbl [0:18];

  logic ready_mode = 1'b0;
  logic ready_force = 1'b0;
  logic rdy;
  exp_t e_pop;
  exp_t held;
  logic held_valid = 1'b0;

  logic [31:0] rnd;
  logic [31:0] instr;
  logic [22:0] row;
  logic [6:0]  f7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] exp_iss;
  logic [31:0] exp_ill;

  alu_issue_decoder #(.XLEN(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op_code  (out_op_code),
    .out_operandA (out_operandA),
    .out_operandB (out_operandB),
    .out_immediate(out_immediate),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal),
    .perf_issued  (perf_issued),
    .perf_illegal (perf_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [11:0] imm, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.imm = imm; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  task automatic addRow(input int idx, input logic [6:0] opc, input logic [2:0] f3,
                        input logic any, input logic [6:0] f7v, input logic [4:0] op);
    tbl[idx] = {opc, f3, any, f7v, op};
  endtask

  // Every legal ALU encoding, listed by mnemonic.
  task automatic buildTable();
    addRow(0,  7'h33, 3'd0, 1'b0, 7'h00, 5'd0);   // ADD
    addRow(1,  7'h33, 3'd0, 1'b0, 7'h20, 5'd1);   // SUB
    addRow(2,  7'h33, 3'd1, 1'b0, 7'h00, 5'd2);   // SLL
    addRow(3,  7'h33, 3'd2, 1'b0, 7'h00, 5'd3);   // SLT
    addRow(4,  7'h33, 3'd3, 1'b0, 7'h00, 5'd4);   // SLTU
    addRow(5,  7'h33, 3'd4, 1'b0, 7'h00, 5'd5);   // XOR
    addRow(6,  7'h33, 3'd5, 1'b0, 7'h00, 5'd6);   // SRL
    addRow(7,  7'h33, 3'd5, 1'b0, 7'h20, 5'd7);   // SRA
    addRow(8,  7'h33, 3'd6, 1'b0, 7'h00, 5'd8);   // OR
    addRow(9,  7'h33, 3'd7, 1'b0, 7'h00, 5'd9);   // AND
    addRow(10, 7'h13, 3'd0, 1'b1, 7'h00, 5'd10);  // ADDI
    addRow(11, 7'h13, 3'd1, 1'b0, 7'h00, 5'd11);  // SLLI
    addRow(12, 7'h13, 3'd2, 1'b1, 7'h00, 5'd12);  // SLTI
    addRow(13, 7'h13, 3'd3, 1'b1, 7'h00, 5'd13);  // SLTUI
    addRow(14, 7'h13, 3'd4, 1'b1, 7'h00, 5'd14);  // XORI
    addRow(15, 7'h13, 3'd5, 1'b0, 7'h00, 5'd15);  // SRLI
    addRow(16, 7'h13, 3'd5, 1'b0, 7'h20, 5'd16);  // SRAI
    addRow(17, 7'h13, 3'd6, 1'b1, 7'h00, 5'd17);  // ORI
    addRow(18, 7'h13, 3'd7, 1'b1, 7'h00, 5'd18);  // ANDI
  endtask

  // Reference decode: look the word up in the encoding table.
  function automatic exp_t refModel(input logic [31:0] iw, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic hit;
    logic [4:0] op;
    hit = 1'b0;
    op  = 5'h1F;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i][22:16] == iw[6:0] && tbl[i][15:13] == iw[14:12] &&
          (tbl[i][12] || tbl[i][11:5] == iw[31:25])) begin
        hit = 1'b1;
        op  = tbl[i][4:0];
      end
    end
    e.op  = hit ? op : 5'h1F;
    e.a   = r1;
    e.b   = (hit && iw[6:0] == 7'h33) ? r2 : 32'd0;
    e.imm = (hit && iw[6:0] == 7'h13) ? iw[31:20] : 12'd0;
    e.rd  = iw[11:7];
    e.ill = ~hit;
    return e;
  endfunction

  // Called at a negedge; holds the request until accepted and returns at the
  // negedge after the accepting posedge.
  task automatic applyStimulus(input logic [31:0] iw, input logic [31:0] r1, input logic [31:0] r2,
                               input exp_t e);
    int waits;
    waits = 0;
    in_valid    = 1'b1;
    in_instr    = iw;
    in_rs1_data = r1;
    in_rs2_data = r2;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every queued entry has come out.
  task automatic drain();
    int waits;
    waits = 0;
    while ((exp_q.size() != 0 || out_valid) && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: chooses out_ready each cycle and scores every pop. Also checks
  // the head holds still while stalled.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_mode) rdy = ($urandom_range(0, 9) < 7);
      else            rdy = ready_force;
      out_ready = rdy;
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid && out_valid)
          checkOutput("head_stable",
                      {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal}, held);
        held_valid = out_valid && !rdy;
        held = {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal};
        if (out_valid && rdy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pop: got op %0h with empty queue expected none", out_op_code);
          end else begin
            e_pop = exp_q.pop_front();
            checkOutput("scoreboard",
                        {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal}, e_pop);
            pop_cnt++;
            if (e_pop.ill) ill_cnt++;
          end
        end
      end
    end
  end

  task automatic checkPerf(input string tag);
`ifdef ALU_DEC_PERF_EN
    exp_iss = pop_cnt;
    exp_ill = ill_cnt;
`else
    exp_iss = 32'd0;
    exp_ill = 32'd0;
`endif
    checkOutput({tag, "_perf_issued"}, perf_issued, exp_iss);
    checkOutput({tag, "_perf_illegal"}, perf_illegal, exp_ill);
  endtask

  initial begin
    buildTable();
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_outputs",
                {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal}, 0);
    checkPerf("reset");

    $display("[TB] ADD with 1-cycle latency");
    ready_force = 1'b1;
    applyStimulus(32'h002081B3, 32'd5, 32'd7, mk(5'd0, 32'd5, 32'd7, 12'd0, 5'd3, 1'b0));
    checkOutput("latency_out_valid", out_valid, 1);
    drain();

    $display("[TB] ADDI and SRAI");
    applyStimulus(32'hFFF00093, 32'd9, 32'h1234, mk(5'd10, 32'd9, 32'd0, 12'hFFF, 5'd1, 1'b0));
    applyStimulus(32'h4030D093, 32'hDEADBEEF, 32'h55, mk(5'd16, 32'hDEADBEEF, 32'd0, 12'h403, 5'd1, 1'b0));
    drain();

    $display("[TB] backpressure to FULL");
    ready_force = 1'b0;
    fork
      begin
        applyStimulus(32'h002081B3, 32'd1, 32'd11, mk(5'd0, 32'd1, 32'd11, 12'd0, 5'd3, 1'b0));
        applyStimulus(32'h002081B3, 32'd2, 32'd22, mk(5'd0, 32'd2, 32'd22, 12'd0, 5'd3, 1'b0));
        applyStimulus(32'h002081B3, 32'd3, 32'd33, mk(5'd0, 32'd3, 32'd33, 12'd0, 5'd3, 1'b0));
      end
      begin
        repeat (2) @(negedge clk);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_out_valid", out_valid, 1);
        @(negedge clk);
        checkOutput("full_held_in_ready", in_ready, 0);
        ready_force = 1'b1;
      end
    join
    drain();

    $display("[TB] reset while FULL");
    ready_force = 1'b0;
    applyStimulus(32'h002081B3, 32'd4, 32'd44, mk(5'd0, 32'd4, 32'd44, 12'd0, 5'd3, 1'b0));
    applyStimulus(32'h002081B3, 32'd5, 32'd55, mk(5'd0, 32'd5, 32'd55, 12'd0, 5'd3, 1'b0));
    checkOutput("prereset_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_outputs",
                {out_op_code, out_operandA, out_operandB, out_immediate, out_rd, out_illegal}, 0);
    exp_q.delete();
    pop_cnt = 0;
    ill_cnt = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    ready_force = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_stale_entry", out_valid, 0);
    checkPerf("post_rst");

    $display("[TB] illegal encodings");
    applyStimulus(32'h00412083, 32'h11, 32'h22, mk(5'h1F, 32'h11, 32'd0, 12'd0, 5'd1, 1'b1));
    applyStimulus(32'h027302B3, 32'h33, 32'h44, mk(5'h1F, 32'h33, 32'd0, 12'd0, 5'd5, 1'b1));
    drain();
    checkPerf("illegal");

    $display("[TB] random traffic");
    ready_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      rnd = $urandom;
      if (rnd[3:0] == 4'd0) begin
        instr = $urandom;
      end else begin
        row = tbl[$urandom_range(0, 18)];
        rnd = $urandom;
        f7 = row[12] ? rnd[6:0] : row[11:5];
        if (rnd[10:8] == 3'd0) f7 = rnd[17:11];
        rnd = $urandom;
        instr = {f7, rnd[4:0], rnd[9:5], row[15:13], rnd[14:10], row[22:16]};
      end
      rs1 = $urandom;
      rs2 = $urandom;
      applyStimulus(instr, rs1, rs2, refModel(instr, rs1, rs2));
    end
    ready_mode = 1'b0;
    ready_force = 1'b1;
    drain();
    checkPerf("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
